// File: rtl/number_analyzer_pkg.sv
// rtl/number_analyzer_pkg.sv - shared types, widths and helpers for number_analyzer
package number_analyzer_pkg;

    localparam int DATA_W = 32;
    localparam int FIB_W  = 33;

    // Largest Fibonacci number representable in DATA_W bits (F47)
    localparam logic [DATA_W-1:0] MAX_FIB32 = 32'd2971215073;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } fib_state_t;

    function automatic logic is_pal32(input logic [DATA_W-1:0] v);
        logic r;
        r = 1'b1;
        for (int i = 0; i < DATA_W/2; i++) begin
            if (v[i] != v[DATA_W-1-i]) begin
                r = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fib_checker.sv
// rtl/fib_checker.sv - iterative Fibonacci membership test with completion flag
module fib_checker
    import number_analyzer_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] a,
    output logic              o_fibo,
    output logic              done
);

    fib_state_t        r_state, w_state_n;
    logic [FIB_W-1:0]  r_f0, r_f1, w_f0_n, w_f1_n;
    logic [DATA_W-1:0] r_a_lat, w_a_lat_n;
    logic              r_done, r_fibo, w_done_n, w_fibo_n;
    logic [FIB_W-1:0]  w_a_ext;
    logic              w_a_changed;

    assign w_a_ext     = {1'b0, r_a_lat};
    assign w_a_changed = (a != r_a_lat);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_INIT;
            r_f0    <= '0;
            r_f1    <= FIB_W'(1);
            r_a_lat <= '0;
            r_done  <= 1'b0;
            r_fibo  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_f0    <= w_f0_n;
            r_f1    <= w_f1_n;
            r_a_lat <= w_a_lat_n;
            r_done  <= w_done_n;
            r_fibo  <= w_fibo_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_f0_n    = r_f0;
        w_f1_n    = r_f1;
        w_a_lat_n = r_a_lat;
        w_done_n  = r_done;
        w_fibo_n  = r_fibo;
        case (r_state)
            ST_INIT: begin
                w_a_lat_n = a;
                w_f0_n    = '0;
                w_f1_n    = FIB_W'(1);
                w_done_n  = 1'b0;
                w_fibo_n  = 1'b0;
                w_state_n = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                // An operand change wins over the compare so a stale result never completes
                if (w_a_changed) begin
                    w_done_n  = 1'b0;
                    w_fibo_n  = 1'b0;
                    w_state_n = ST_INIT;
                end else if (r_f0 == w_a_ext) begin
                    w_done_n  = 1'b1;
                    w_fibo_n  = 1'b1;
                    w_state_n = ST_DONE;
                end else if (r_f0 > w_a_ext) begin
                    w_done_n  = 1'b1;
                    w_fibo_n  = 1'b0;
                    w_state_n = ST_DONE;
                end else begin
                    w_f0_n = r_f1;
                    w_f1_n = r_f0 + r_f1;
                end
            end
            ST_DONE: begin
                if (w_a_changed) begin
                    w_done_n  = 1'b0;
                    w_fibo_n  = 1'b0;
                    w_state_n = ST_INIT;
                end
            end
            default: begin
                w_state_n = ST_INIT;
            end
        endcase
    end

    assign o_fibo = r_fibo;
    assign done   = r_done;

endmodule

// File: rtl/odd_check.sv
// rtl/odd_check.sv - combinational odd-value detector
module odd_check
    import number_analyzer_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    output logic              o_odd
);

    assign o_odd = a[0];

endmodule

// File: rtl/palindrome_check.sv
// rtl/palindrome_check.sv - combinational 32-bit binary palindrome detector
module palindrome_check
    import number_analyzer_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    output logic              o_pal
);

    assign o_pal = is_pal32(a);

endmodule

// File: rtl/number_analyzer.sv
// rtl/number_analyzer.sv - Fibonacci, palindrome and odd classification of a 32-bit word
module number_analyzer
    import number_analyzer_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] a,
    output logic              o_fibo,
    output logic              o_pal,
    output logic              o_odd,
    output logic              done
);

    logic w_fibo, w_done, w_pal, w_odd;

    fib_checker u_fib_checker (
        .clock  (clock),
        .reset  (reset),
        .a      (a),
        .o_fibo (w_fibo),
        .done   (w_done)
    );

    palindrome_check u_palindrome_check (
        .a     (a),
        .o_pal (w_pal)
    );

    odd_check u_odd_check (
        .a     (a),
        .o_odd (w_odd)
    );

    assign o_fibo = w_fibo;
    assign done   = w_done;
    assign o_pal  = w_pal;
    assign o_odd  = w_odd;

endmodule

// File: tb/tb_number_analyzer.sv
// tb/tb_number_analyzer.sv - directed self-checking bench for number_analyzer
module tb_number_analyzer;
    import number_analyzer_pkg::*;

    logic        clock;
    logic        reset;
    logic [31:0] a;
    logic        o_fibo, o_pal, o_odd, done;

    int checks   = 0;
    int failures = 0;

    number_analyzer dut (
        .clock  (clock),
        .reset  (reset),
        .a      (a),
        .o_fibo (o_fibo),
        .o_pal  (o_pal),
        .o_odd  (o_odd),
        .done   (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts rising edges (reset high) until done, bounded
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!done && n < 100);
    endtask

    task automatic run_vec(input string tag, input logic [31:0] v, input int exp_lat,
                           input logic exp_fibo, input logic exp_pal, input logic exp_odd);
        int n;
        @(negedge clock);
        a     = v;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check({tag, "_rst_done"}, done, 1'b0);
        reset = 1'b1;
        wait_done(n);
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_fibo"}, o_fibo, exp_fibo);
        check({tag, "_pal"}, o_pal, exp_pal);
        check({tag, "_odd"}, o_odd, exp_odd);
    endtask

    initial begin
        int n;
        logic [31:0] r;
        reset = 1'b0;
        a     = 32'd0;
        repeat (2) @(negedge clock);
        check("reset_done", done, 1'b0);
        check("reset_fibo", o_fibo, 1'b0);

        run_vec("big",   32'h3B94D943,  47, 1'b0, 1'b0, 1'b1);
        run_vec("f28",   32'd317811,    30, 1'b1, 1'b0, 1'b1);
        run_vec("f47",   MAX_FIB32,     49, 1'b1, 1'b0, 1'b1);
        run_vec("zero",  32'd0,          2, 1'b1, 1'b1, 1'b0);
        run_vec("one",   32'd1,          3, 1'b1, 1'b0, 1'b1);
        run_vec("max",   32'hFFFFFFFF,  50, 1'b0, 1'b1, 1'b1);
        run_vec("f47p1", 32'd2971215074,50, 1'b0, 1'b0, 1'b0);

        // Combinational outputs follow a without a clock edge
        @(negedge clock);
        a = 32'h80000001;
        #1;
        check("pal_8001", o_pal, 1'b1);
        check("odd_8001", o_odd, 1'b1);

        // Reset asserted at edge 10 of an F28 run aborts it
        @(negedge clock);
        a     = 32'd317811;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (9) @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("abort_done", done, 1'b0);
        check("abort_fibo", o_fibo, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        wait_done(n);
        check("abort_relat", n, 30);
        check("abort_refibo", o_fibo, 1'b1);

        // Operand change 8 -> 9 restarts the check
        run_vec("eight", 32'd8, 8, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        a = 32'd9;
        @(posedge clock);
        #1;
        check("chg_done_drop", done, 1'b0);
        check("chg_fibo_drop", o_fibo, 1'b0);
        wait_done(n);
        check("chg_lat", n, 9);
        check("chg_fibo", o_fibo, 1'b0);
        repeat (3) @(negedge clock);
        check("chg_hold_done", done, 1'b1);

        for (int i = 0; i < 10000; i++) begin
            r = $urandom;
            a = r;
            #1;
            check("rand_pal", o_pal, (r == {<<{r}}));
            check("rand_odd", o_odd, (r % 2 == 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
